// File: rtl/pcpi_bridge_pkg.sv
// Shared constants, state encoding and sizing helper for the PCPI serial bridge.
package pcpi_bridge_pkg;

    localparam int DEF_SEG_W  = 4;
    localparam int DEF_INSN_W = 32;
    localparam int DEF_RD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } bridge_state_e;

    // Segment/result counter width; never narrower than one bit.
    function automatic int cnt_width(input int nseg, input int nres);
        int m;
        m = (nseg > nres) ? nseg : nres;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pcpi_serial_bridge_if.sv
// PCPI coprocessor bus between the bridge (master) and the coprocessor (slave).
interface pcpi_serial_bridge_if
    import pcpi_bridge_pkg::*;
#(
    parameter int INSN_W = DEF_INSN_W,
    parameter int RD_W   = DEF_RD_W
);
    logic              pcpi_valid;
    logic [INSN_W-1:0] pcpi_insn;
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic              pcpi_wait;
    logic [RD_W-1:0]   pcpi_rd;

    modport master (
        output pcpi_valid, pcpi_insn,
        input  pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );

    modport slave (
        input  pcpi_valid, pcpi_insn,
        output pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );
endinterface

// File: rtl/seg_serializer.sv
// Parallel-load shift register that emits a W-bit word as SEG_W-bit segments,
// LSB segment first, over a valid/ready handshake.
module seg_serializer #(
    parameter int SEG_W = 4,
    parameter int W     = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             active,
    output logic [SEG_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last
);
    localparam int NSEG = W / SEG_W;

    logic [W-1:0]     shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fire;

    assign out_valid = active;
    assign out_data  = shift_reg[SEG_W-1:0];
    assign fire      = active && out_ready;
    assign last      = fire && (cnt_reg == CNT_W'(NSEG - 1));

    // Only an accepted segment shifts, so the output holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= din;
            cnt_reg   <= '0;
        end else if (fire) begin
            shift_reg <= shift_reg >> SEG_W;
            cnt_reg   <= last ? '0 : cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pcpi_serial_bridge.sv
// Assembles a PCPI instruction from serial segments, issues it with a watchdog,
// and streams any returned result back out segment by segment.
module pcpi_serial_bridge
    import pcpi_bridge_pkg::*;
#(
    parameter int SEG_W   = DEF_SEG_W,
    parameter int INSN_W  = DEF_INSN_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEG_W-1:0]     seg_in,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    input  logic                 abort,
    pcpi_serial_bridge_if.master pcpi,
    output logic [SEG_W-1:0]     res_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout
);
    localparam int NSEG  = INSN_W / SEG_W;
    localparam int NRES  = RD_W / SEG_W;
    localparam int CNT_W = cnt_width(NSEG, NRES);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] LOAD  = ST_LOAD;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  seg_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [INSN_W-1:0] insn_reg;
    logic              done_reg;
    logic              err_reg;

    logic seg_fire;
    logic issue_expire;
    logic load_res;
    logic drain_last;

    assign seg_ready       = (state_reg == IDLE) || (state_reg == LOAD);
    assign seg_fire        = seg_valid && seg_ready;
    assign busy            = (state_reg != IDLE);
    assign done            = done_reg;
    assign err_timeout     = err_reg;
    assign pcpi.pcpi_valid = (state_reg == ISSUE);
    assign pcpi.pcpi_insn  = insn_reg;

    // Expiry fires on the cycle the counter would reach zero; ready always beats it.
    assign issue_expire = (state_reg == ISSUE) && !pcpi.pcpi_ready && !pcpi.pcpi_wait
                          && (tmo_cnt_reg <= TMO_W'(1));
    assign load_res     = (state_reg == ISSUE) && pcpi.pcpi_ready && pcpi.pcpi_wr && !abort;

    seg_serializer #(
        .SEG_W (SEG_W),
        .W     (RD_W),
        .CNT_W (CNT_W)
    ) u_res_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort),
        .load      (load_res),
        .din       (pcpi.pcpi_rd),
        .active    (state_reg == DRAIN),
        .out_data  (res_out),
        .out_valid (res_valid),
        .out_ready (res_ready),
        .last      (drain_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            seg_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            insn_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (abort) begin
                state_reg   <= IDLE;
                seg_cnt_reg <= '0;
                tmo_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE, LOAD: begin
                        if (seg_fire) begin
                            insn_reg[seg_cnt_reg*SEG_W +: SEG_W] <= seg_in;
                            if (seg_cnt_reg == CNT_W'(NSEG - 1)) begin
                                seg_cnt_reg <= '0;
                                tmo_cnt_reg <= TMO_W'(TIMEOUT);
                                state_reg   <= ISSUE;
                            end else begin
                                seg_cnt_reg <= seg_cnt_reg + CNT_W'(1);
                                state_reg   <= LOAD;
                            end
                        end
                    end
                    ISSUE: begin
                        if (pcpi.pcpi_ready) begin
                            tmo_cnt_reg <= '0;
                            done_reg    <= !pcpi.pcpi_wr;
                            state_reg   <= pcpi.pcpi_wr ? DRAIN : IDLE;
                        end else if (issue_expire) begin
                            tmo_cnt_reg <= '0;
                            err_reg     <= 1'b1;
                            state_reg   <= IDLE;
                        end else if (pcpi.pcpi_wait) begin
                            tmo_cnt_reg <= TMO_W'(TIMEOUT);
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg - TMO_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_last) begin
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/pcpi_serial_bridge.md
PCPI_SERIAL_BRIDGE -- requirements
Module: pcpi_serial_bridge

Interface
REQ-001 Parameters SHALL be, one per line:
- SEG_W, default 4, segment width in bits.
- INSN_W, default 32, instruction width.
- RD_W, default 32, result width.
- TIMEOUT, default 256, maximum wait cycles for pcpi_ready.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- seg_in  in  SEG_W  instruction segment.
- seg_valid  in  1  segment offered.
- seg_ready  out  1  segment accepted.
- abort  in  1  synchronous return to IDLE.
- pcpi_valid  out  1  instruction valid to coprocessor.
- pcpi_insn  out  INSN_W  assembled instruction.
- pcpi_ready  in  1  coprocessor done.
- pcpi_wr  in  1  result write request.
- pcpi_wait  in  1  coprocessor busy.
- pcpi_rd  in  RD_W  result.
- res_out  out  SEG_W  result segment.
- res_valid  out  1  result segment offered.
- res_ready  in  1  result segment taken.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err_timeout  out  1  one-cycle timeout pulse.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 INSN_W and RD_W SHALL be integer multiples of SEG_W; NSEG=INSN_W/SEG_W, NRES=RD_W/SEG_W.

Function
REQ-005 States SHALL be IDLE, LOAD, ISSUE, DRAIN.
REQ-006 seg_ready SHALL be 1 in IDLE and LOAD, and 0 otherwise; a transfer is seg_valid&&seg_ready.
REQ-007 The k-th transfer (k=0..NSEG-1) SHALL write pcpi_insn[k*SEG_W +: SEG_W] (LSB segment first).
- IDLE moves to LOAD on the first transfer.
- The transfer with k=NSEG-1 moves to ISSUE and clears the segment counter.
REQ-008 In ISSUE, pcpi_valid SHALL be 1, pcpi_insn SHALL be stable, and pcpi_valid SHALL be held until the cycle pcpi_ready=1 is sampled.
REQ-009 On pcpi_ready with pcpi_wr=1, the bridge SHALL latch pcpi_rd, drop pcpi_valid next cycle and enter DRAIN.
REQ-010 On pcpi_ready with pcpi_wr=0, the bridge SHALL drop pcpi_valid, pulse done and enter IDLE.
REQ-011 The timeout counter SHALL:
- load TIMEOUT on entry to ISSUE;
- reload whenever pcpi_wait=1;
- decrement otherwise.
REQ-012 When the timeout counter reaches 0 without pcpi_ready, the bridge SHALL drop pcpi_valid, pulse err_timeout and enter IDLE.
REQ-013 If pcpi_ready and timeout expiry occur in the same cycle, pcpi_ready SHALL win.
REQ-014 In DRAIN, res_out SHALL present result segment j (LSB first) with res_valid=1.
- j advances on res_valid&&res_ready.
- res_out is stable while res_valid&&!res_ready.
REQ-015 Acceptance of segment NRES-1 SHALL pulse done and enter IDLE.
REQ-016 res_valid SHALL be 0 outside DRAIN.
REQ-017 abort SHALL return the bridge to IDLE next cycle from any state.
- Counters and pcpi_valid are cleared.
- done and err_timeout are not pulsed.
- abort takes priority over all other events.
REQ-018 Segment and result counters SHALL be $clog2(max(NSEG,NRES)) bits wide; the timeout counter SHALL be $clog2(TIMEOUT+1) bits wide.

Reset
REQ-019 On rst_n=0 the bridge SHALL go to IDLE immediately, with:
- pcpi_valid=0, res_valid=0, done=0, err_timeout=0, busy=0;
- pcpi_insn=0, result register=0;
- all counters=0.
REQ-020 Reset mid-transfer SHALL discard any partial instruction or result.

Structure
REQ-021 The state enum and the default SEG_W, INSN_W and RD_W constants SHALL live in shared package pcpi_bridge_pkg.
REQ-022 Serialisation SHALL be implemented in one sub-module, seg_serializer (parametrised width, LOAD/shift, valid/ready).

Verification
REQ-023 Load test: 8 nibbles 0x7,0x6,..,0x0 with defaults -> pcpi_insn=0x01234567 and pcpi_valid high on the cycle after the 8th transfer.
REQ-024 Result test: pcpi_ready=1, pcpi_wr=1, pcpi_rd=0xDEADBEEF -> res_out sequence F,E,E,B,D,A,E,D, then done pulse, then IDLE.
REQ-025 Backpressure test: hold res_ready=0 for 5 cycles mid-drain -> res_out is held stable and no segment is lost.
REQ-026 Timeout test: TIMEOUT=4, pcpi_ready never asserted, pcpi_wait=0 -> err_timeout pulses 4 cycles after entering ISSUE and pcpi_valid drops.
REQ-027 Wait-extension test: pcpi_wait=1 for 10 cycles, then pcpi_ready with pcpi_wr=0 -> no timeout and a single done pulse.
REQ-028 Abort/reset test: abort after 3 segments, or rst_n low during DRAIN -> IDLE, and the next full load produces a correct instruction.
